main_decoder: RTL and testbench



---
 rtl/main_decoder_pkg.sv | 43 ++++
 rtl/main_decoder_lut.sv | 58 +++++
 rtl/main_decoder.sv | 54 +++++
 tb/tb_main_decoder.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/main_decoder_pkg.sv
// Shared constants and control-word type for the MIPS main control decoder.
// The Jump field exists only when MAIN_DECODER_JUMP_EN is defined.
package main_decoder_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ULAOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;

    localparam logic [ULAOP_W-1:0] ULAOP_ADD   = 2'b00;
    localparam logic [ULAOP_W-1:0] ULAOP_SUB   = 2'b01;
    localparam logic [ULAOP_W-1:0] ULAOP_FUNCT = 2'b10;

    typedef struct packed {
        logic               reg_write;
        logic               reg_dst;
        logic               ula_src;
        logic               branch;
        logic               mem_write;
        logic               mem_to_reg;
        logic [ULAOP_W-1:0] ula_op;
        logic               illegal;
`ifdef MAIN_DECODER_JUMP_EN
        logic               jump;
`endif
    } ctrl_t;

    localparam int unsigned CTRL_W = $bits(ctrl_t);

    // Safe no-op word for unsupported opcodes: nothing written, nothing taken.
    function automatic ctrl_t ctrl_illegal();
        ctrl_t c;
        c         = '0;
        c.illegal = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/main_decoder_lut.sv
// Pure combinational opcode-to-control-word table; holds no state.
// Opcode J is decoded only when MAIN_DECODER_JUMP_EN is defined.
module main_decoder_lut
    import main_decoder_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode_i,
    output logic [CTRL_W-1:0]   ctrl_c_o
);

    ctrl_t ctrl_c;

    // Unlisted and unknown opcodes fall through to the illegal no-op word.
    always_comb begin
        ctrl_c = ctrl_illegal();
        case (opcode_i)
            OP_RTYPE: begin
                ctrl_c           = '0;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.reg_dst   = 1'b1;
                ctrl_c.ula_op    = ULAOP_FUNCT;
            end
            OP_LW: begin
                ctrl_c            = '0;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.ula_src    = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.ula_op     = ULAOP_ADD;
            end
            OP_SW: begin
                ctrl_c           = '0;
                ctrl_c.ula_src   = 1'b1;
                ctrl_c.mem_write = 1'b1;
                ctrl_c.ula_op    = ULAOP_ADD;
            end
            OP_BEQ: begin
                ctrl_c        = '0;
                ctrl_c.branch = 1'b1;
                ctrl_c.ula_op = ULAOP_SUB;
            end
            OP_ADDI: begin
                ctrl_c           = '0;
                ctrl_c.reg_write = 1'b1;
                ctrl_c.ula_src   = 1'b1;
                ctrl_c.ula_op    = ULAOP_ADD;
            end
`ifdef MAIN_DECODER_JUMP_EN
            OP_J: begin
                ctrl_c      = '0;
                ctrl_c.jump = 1'b1;
            end
`endif
            default: ctrl_c = ctrl_illegal();
        endcase
    end

    assign ctrl_c_o = ctrl_c;

endmodule

// File: rtl/main_decoder.sv
// Main control decoder: registers the decoded control word once per cycle.
// Define MAIN_DECODER_JUMP_EN to add the Jump port and decode opcode J.
module main_decoder
    import main_decoder_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] Opcode,
    output logic [ULAOP_W-1:0]  ULAOp,
    output logic                MemtoReg,
    output logic                MemWrite,
    output logic                Branch,
    output logic                ULASrc,
    output logic                RegDst,
    output logic                RegWrite,
`ifdef MAIN_DECODER_JUMP_EN
    output logic                Jump,
`endif
    output logic                Illegal
);

    logic [CTRL_W-1:0] ctrl_c;
    ctrl_t             ctrl_d;
    ctrl_t             ctrl_q;

    main_decoder_lut u_lut (
        .opcode_i (Opcode),
        .ctrl_c_o (ctrl_c)
    );

    assign ctrl_d = ctrl_t'(ctrl_c);

    // Reset clears the word asynchronously, discarding any in-flight decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign RegWrite = ctrl_q.reg_write;
    assign RegDst   = ctrl_q.reg_dst;
    assign ULASrc   = ctrl_q.ula_src;
    assign Branch   = ctrl_q.branch;
    assign MemWrite = ctrl_q.mem_write;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign ULAOp    = ctrl_q.ula_op;
    assign Illegal  = ctrl_q.illegal;
`ifdef MAIN_DECODER_JUMP_EN
    assign Jump     = ctrl_q.jump;
`endif

endmodule

// File: tb/tb_main_decoder.sv
// Directed-vector bench for main_decoder; expected words are hand-computed.
// Word layout: {RegWrite, RegDst, ULASrc, Branch, MemWrite, MemtoReg, ULAOp[1:0], Illegal}.
module tb_main_decoder;

    localparam logic [8:0] W_ZERO = 9'b0_0_0_0_0_0_00_0;
    localparam logic [8:0] W_RTYP = 9'b1_1_0_0_0_0_10_0;
    localparam logic [8:0] W_LW   = 9'b1_0_1_0_0_1_00_0;
    localparam logic [8:0] W_SW   = 9'b0_0_1_0_1_0_00_0;
    localparam logic [8:0] W_BEQ  = 9'b0_0_0_1_0_0_01_0;
    localparam logic [8:0] W_ADDI = 9'b1_0_1_0_0_0_00_0;
    localparam logic [8:0] W_ILL  = 9'b0_0_0_0_0_0_00_1;
`ifdef MAIN_DECODER_JUMP_EN
    localparam logic [8:0] W_J    = W_ZERO;
    localparam logic       J_J    = 1'b1;
`else
    localparam logic [8:0] W_J    = W_ILL;
    localparam logic       J_J    = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [5:0] Opcode;
    logic [1:0] ULAOp;
    logic       MemtoReg, MemWrite, Branch, ULASrc, RegDst, RegWrite, Illegal;
    logic       jump_obs;

    int n_vec;
    int n_bad;

    main_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Opcode   (Opcode),
        .ULAOp    (ULAOp),
        .MemtoReg (MemtoReg),
        .MemWrite (MemWrite),
        .Branch   (Branch),
        .ULASrc   (ULASrc),
        .RegDst   (RegDst),
        .RegWrite (RegWrite),
`ifdef MAIN_DECODER_JUMP_EN
        .Jump     (Jump_w),
`endif
        .Illegal  (Illegal)
    );

`ifdef MAIN_DECODER_JUMP_EN
    logic Jump_w;
    assign jump_obs = Jump_w;
`else
    assign jump_obs = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] obs_word();
        return {RegWrite, RegDst, ULASrc, Branch, MemWrite, MemtoReg, ULAOp, Illegal};
    endfunction

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [8:0] w, input logic j);
        chk(tag, 16'(obs_word()), 16'(w));
        chk({tag, "_jump"}, 16'(jump_obs), 16'(j));
    endtask

    typedef struct {
        logic [5:0] op;
        logic [8:0] w;
        logic       j;
        string      name;
    } vec_t;

    vec_t vecs[$];
    logic [5:0] xop;
    logic [8:0] prev_w;
    logic       prev_j;

    initial begin
        n_vec = 0;
        n_bad = 0;
        vecs = '{
            '{6'b000000, W_RTYP, 1'b0, "rtype"},
            '{6'b100011, W_LW,   1'b0, "lw"},
            '{6'b101011, W_SW,   1'b0, "sw"},
            '{6'b000100, W_BEQ,  1'b0, "beq"},
            '{6'b001000, W_ADDI, 1'b0, "addi"},
            '{6'b111111, W_ILL,  1'b0, "op3f"},
            '{6'b000010, W_J,    J_J,  "j"},
            '{6'b000011, W_ILL,  1'b0, "op03"},
            '{6'b100011, W_LW,   1'b0, "lw2"},
            '{6'b101000, W_ILL,  1'b0, "op28"}
        };

        rst_n  = 1'b0;
        Opcode = 6'b000000;
        #3;
        chk_all("rst_async", W_ZERO, 1'b0);
        @(posedge clk); #1;
        chk_all("rst_hold_edge", W_ZERO, 1'b0);

        @(negedge clk) rst_n = 1'b1;
        #1 chk_all("rst_release_pre_edge", W_ZERO, 1'b0);
        @(posedge clk); #1;
        chk_all("first_rtype", W_RTYP, 1'b0);
        prev_w = W_RTYP;
        prev_j = 1'b0;

        // New opcode must not appear until the next rising edge.
        foreach (vecs[i]) begin
            @(negedge clk) Opcode = vecs[i].op;
            #1 chk_all({vecs[i].name, "_hold"}, prev_w, prev_j);
            @(posedge clk); #1;
            chk_all(vecs[i].name, vecs[i].w, vecs[i].j);
            prev_w = vecs[i].w;
            prev_j = vecs[i].j;
        end

        @(negedge clk) Opcode = 6'b100011;
        @(posedge clk); #1;
        chk_all("lw_before_rst", W_LW, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_all("rst_midcycle", W_ZERO, 1'b0);
        @(posedge clk); #1;
        chk_all("rst_mid_edge", W_ZERO, 1'b0);
        @(negedge clk) begin
            rst_n  = 1'b1;
            Opcode = 6'b001000;
        end
        @(posedge clk); #1;
        chk_all("addi_after_rst", W_ADDI, 1'b0);

        xop = 'x;
        @(negedge clk) Opcode = xop;
        @(posedge clk); #1;
        chk("x_no_unknown", 16'($isunknown({obs_word(), jump_obs})), 16'd0);
        // A 2-state simulator resolves X to a concrete value; judge by what the DUT saw.
        if ($isunknown(Opcode) || Opcode == 6'b111111) begin
            chk_all("x_illegal", W_ILL, 1'b0);
        end else begin
            chk("x_resolved_illegal_or_legal", 16'(Illegal),
                16'((Opcode == 6'b000000 || Opcode == 6'b100011 || Opcode == 6'b101011 ||
                     Opcode == 6'b000100 || Opcode == 6'b001000 ||
                     (Opcode == 6'b000010 && J_J)) ? 1'b0 : 1'b1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
